// File: rtl/alu_arbiter_if.sv
// Request/response handshakes for two requesters plus the shared ALU operand/result bus.
// Carries no state; timing is set by the arbiter and the ALU attached to it.
// Flow control is valid/ready on each requester's request and response channels.
interface alu_arbiter_if;
    logic       req0_valid;
    logic       req0_ready;
    logic [7:0] req0_a;
    logic [7:0] req0_b;
    logic [3:0] req0_op;
    logic       rsp0_valid;
    logic       rsp0_ready;
    logic [7:0] rsp0_data;
    logic       rsp0_err;

    logic       req1_valid;
    logic       req1_ready;
    logic [7:0] req1_a;
    logic [7:0] req1_b;
    logic [3:0] req1_op;
    logic       rsp1_valid;
    logic       rsp1_ready;
    logic [7:0] rsp1_data;
    logic       rsp1_err;

    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_s;
    logic [7:0] alu_result;
    logic       busy;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op, rsp0_ready,
        input  req1_valid, req1_a, req1_b, req1_op, rsp1_ready,
        input  alu_result,
        output req0_ready, rsp0_valid, rsp0_data, rsp0_err,
        output req1_ready, rsp1_valid, rsp1_data, rsp1_err,
        output alu_a, alu_b, alu_s, busy
    );

    // Requesters and ALU side
    modport master (
        output req0_valid, req0_a, req0_b, req0_op, rsp0_ready,
        output req1_valid, req1_a, req1_b, req1_op, rsp1_ready,
        output alu_result,
        input  req0_ready, rsp0_valid, rsp0_data, rsp0_err,
        input  req1_ready, rsp1_valid, rsp1_data, rsp1_err,
        input  alu_a, alu_b, alu_s, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one registered ALU between two requesters, one operation at a time.
// Latency: accept to response valid is 3 cycles (supported op) or 1 cycle (unsupported op).
// Backpressure: request ready only in IDLE; RESPOND holds until the granted port takes the result.
module alu_arbiter (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESPOND} state_t;

    state_t     state;
    state_t     state_nxt;
    logic       rr;
    logic       gnt_id;
    logic       win;
    logic       any_valid;
    logic       accept;
    logic       win_unsup;
    logic       rdy0;
    logic       rdy1;
    logic [7:0] win_a;
    logic [7:0] win_b;
    logic [3:0] win_op;
    logic [7:0] alu_a_q;
    logic [7:0] alu_b_q;
    logic [3:0] alu_s_q;
    logic [7:0] data_q;
    logic       err_q;

    // Pick the winner: rr breaks ties, a lone requester always wins
    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        win       = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            win = rr;
        end else if (bus.req1_valid) begin
            win = 1'b1;
        end
        win_a     = win ? bus.req1_a  : bus.req0_a;
        win_b     = win ? bus.req1_b  : bus.req0_b;
        win_op    = win ? bus.req1_op : bus.req0_op;
        // 0010 and 0100..0111 have no ALU function and are answered locally
        win_unsup = (win_op == 4'b0010) || (win_op[3:2] == 2'b01);
    end

    // Next state and request handshake
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        rdy0      = 1'b0;
        rdy1      = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid && !reset) begin
                    accept    = 1'b1;
                    rdy0      = ~win;
                    rdy1      = win;
                    state_nxt = win_unsup ? RESPOND : ISSUE;
                end
            end
            ISSUE:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = RESPOND;
            RESPOND: begin
                if (gnt_id ? bus.rsp1_ready : bus.rsp0_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant bookkeeping, ALU operand registers and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rr      <= 1'b0;
            gnt_id  <= 1'b0;
            alu_a_q <= 8'h00;
            alu_b_q <= 8'h00;
            alu_s_q <= 4'h0;
            data_q  <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                gnt_id <= win;
                rr     <= ~win;
                err_q  <= win_unsup;
                if (win_unsup) begin
                    // ALU operands keep their previous value
                    data_q <= 8'h00;
                end else begin
                    alu_a_q <= win_a;
                    alu_b_q <= win_b;
                    alu_s_q <= win_op;
                end
            end
            if (state == CAPTURE) begin
                data_q <= bus.alu_result;
                err_q  <= 1'b0;
            end
        end
    end

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign bus.rsp0_valid = (state == RESPOND) && !gnt_id;
    assign bus.rsp1_valid = (state == RESPOND) && gnt_id;
    assign bus.rsp0_data  = data_q;
    assign bus.rsp1_data  = data_q;
    assign bus.rsp0_err   = err_q;
    assign bus.rsp1_err   = err_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_s      = alu_s_q;
    assign bus.busy       = (state != IDLE);

endmodule
